// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: the fetch stage of the pipelined CPU. It owns the
// program counter and drives the ROM address. It captures the ROM word into the
// IF/ID register, handles stall, downstream redirect and halt, and provides
// pre-decoded opcode class flags.
//
// Optional build macro: FETCH_ILLEGAL_TRAP_EN
//   defined   - an illegal opcode (>= 11011) stops fetch the same way halt does.
//   undefined - an illegal opcode is fetched normally and pc advances.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_RUN     | fetching one word per un-stalled cycle, pc advancing
// S_HALTED  | halt (or trap) latched, pc frozen, ID receives bubbles
//
// Only a redirect or a reset leaves S_HALTED.

module instruction_fetch_unit #(
    parameter int          PC_W     = 16,
    parameter int unsigned RESET_PC = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc,
    input  logic [8:0]      instruction,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            id_valid,
    output logic [4:0]      id_opcode,
    output logic [3:0]      id_operand,
    output logic [PC_W-1:0] id_pc,
    output logic            id_is_alu,
    output logic            id_is_branch,
    output logic            id_is_jump,
    output logic            id_is_mem,
    output logic            id_illegal,
    output logic            halted
);

    localparam logic [4:0] OP_ADD     = 5'b00000;
    localparam logic [4:0] OP_SUB     = 5'b00001;
    localparam logic [4:0] OP_BR_LO   = 5'b01111;
    localparam logic [4:0] OP_BR_HI   = 5'b10011;
    localparam logic [4:0] OP_LD      = 5'b10110;
    localparam logic [4:0] OP_ST      = 5'b10111;
    localparam logic [4:0] OP_JUMP    = 5'b11000;
    localparam logic [4:0] OP_HALT    = 5'b11010;
    localparam logic [4:0] OP_ILL_MIN = 5'b11011;

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic            r_id_valid;
    logic [4:0]      r_id_opcode;
    logic [3:0]      r_id_operand;
    logic [PC_W-1:0] r_id_pc;
    logic            r_halted;

    logic [4:0]      w_fetch_op;
    logic            w_stop;

    assign w_fetch_op = instruction[8:4];

    // Decide whether the word being fetched ends fetching.
`ifdef FETCH_ILLEGAL_TRAP_EN
    assign w_stop = (w_fetch_op == OP_HALT) || (w_fetch_op >= OP_ILL_MIN);
`else
    assign w_stop = (w_fetch_op == OP_HALT);
`endif

    // Fetch FSM. Redirect beats stall, and stall beats a normal fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_pc         <= PC_W'(RESET_PC);
            r_id_valid   <= 1'b0;
            r_id_opcode  <= 5'b0;
            r_id_operand <= 4'b0;
            r_id_pc      <= '0;
            r_halted     <= 1'b0;
        end else if (redirect_valid) begin
            // The instruction in ID is younger than the branch, so it is
            // flushed. A latched halt is flushed as well.
            r_pc       <= redirect_pc;
            r_id_valid <= 1'b0;
            r_state    <= S_RUN;
            r_halted   <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                S_RUN: begin
                    r_id_opcode  <= w_fetch_op;
                    r_id_operand <= instruction[3:0];
                    r_id_pc      <= r_pc;
                    r_id_valid   <= 1'b1;
                    if (w_stop) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                S_HALTED: begin
                    r_id_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign pc         = r_pc;
    assign id_valid   = r_id_valid;
    assign id_opcode  = r_id_opcode;
    assign id_operand = r_id_operand;
    assign id_pc      = r_id_pc;
    assign halted     = r_halted;

    // The class flags are decoded from the registered opcode and are only
    // meaningful when ID holds a real instruction.
    assign id_is_alu    = r_id_valid && ((r_id_opcode == OP_ADD) || (r_id_opcode == OP_SUB));
    assign id_is_branch = r_id_valid && (r_id_opcode >= OP_BR_LO) && (r_id_opcode <= OP_BR_HI);
    assign id_is_jump   = r_id_valid && (r_id_opcode == OP_JUMP);
    assign id_is_mem    = r_id_valid && ((r_id_opcode == OP_LD) || (r_id_opcode == OP_ST));
    assign id_illegal   = r_id_valid && (r_id_opcode >= OP_ILL_MIN);

endmodule
